// File: rtl/leaf_egress_arbiter_if.sv
// Bundle between the user-side output streams, the credit return path and the
// BFT egress of one leaf. The arbiter sits on the slave side.
interface leaf_egress_arbiter_if #(
  parameter int NUM_OUT_PORTS = 5,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]                  din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]                               vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]                               ack_interface2user;
  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg;
  logic                                                   credit_upd_vld;
  logic [NUM_PORT_BITS-1:0]                               credit_upd_port;
  logic [NUM_ADDR_BITS:0]                                 credit_upd_amount;
  logic                                                   resend;
  logic [PACKET_BITS-1:0]                                 dout_leaf_interface2bft;
  logic                                                   credit_err;

  modport master (
    output din_leaf_user2interface, vld_user2interface, dest_cfg,
           credit_upd_vld, credit_upd_port, credit_upd_amount, resend,
    input  ack_interface2user, dout_leaf_interface2bft, credit_err
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface, dest_cfg,
           credit_upd_vld, credit_upd_port, credit_upd_amount, resend,
    output ack_interface2user, dout_leaf_interface2bft, credit_err
  );
endinterface

// File: rtl/leaf_egress_arbiter.sv
// Credit-based round-robin arbiter merging NUM_OUT_PORTS user streams onto one
// BFT egress; each granted payload is tagged with its destination and write pointer.
module leaf_egress_arbiter #(
  parameter int NUM_OUT_PORTS = 5,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 49
) (
  input  logic                  clk,
  input  logic                  reset_n,
  leaf_egress_arbiter_if.slave  bus
);

  localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CW        = NUM_ADDR_BITS + 1;
  localparam int GW        = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(1) << NUM_ADDR_BITS;

  logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] wptr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] wptr_d   [NUM_OUT_PORTS];
  logic [GW-1:0]            lastGrant_q, lastGrant_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     creditErr_q, creditErr_d;

  logic [PAYLOAD_BITS-1:0]  payload [NUM_OUT_PORTS];
  logic [DEST_BITS-1:0]     dest    [NUM_OUT_PORTS];
  logic [CW:0]              creditSum [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grantOneHot;
  logic [NUM_OUT_PORTS-1:0] updHit;
  logic                     grantVld;
  logic [GW-1:0]            grantIdx;
  logic [GW:0]              candIdx;
  logic                     updBadPort;
  logic                     anyOverflow;

  // Eligibility is gated by reset_n so no ack can leak out while held in reset.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      payload[i]  = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      dest[i]     = bus.dest_cfg[i*DEST_BITS +: DEST_BITS];
      eligible[i] = reset_n && bus.vld_user2interface[i] &&
                    (credit_q[i] != '0) && !bus.resend;
    end
  end

  always_comb begin
    grantVld = 1'b0;
    grantIdx = lastGrant_q;
    candIdx  = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      candIdx = {1'b0, lastGrant_q} + (GW+1)'(k);
      if (candIdx >= (GW+1)'(NUM_OUT_PORTS)) begin
        candIdx = candIdx - (GW+1)'(NUM_OUT_PORTS);
      end
      if (!grantVld && eligible[candIdx[GW-1:0]]) begin
        grantVld = 1'b1;
        grantIdx = candIdx[GW-1:0];
      end
    end
  end

  always_comb begin
    dout_d = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      grantOneHot[i] = grantVld && (grantIdx == GW'(i));
      if (grantOneHot[i]) begin
        dout_d = {1'b1, dest[i], wptr_q[i], payload[i]};
      end
    end
  end

  // Grant and credit return on the same port net out in a single cycle.
  always_comb begin
    updBadPort  = bus.credit_upd_vld &&
                  ({1'b0, bus.credit_upd_port} >= (NUM_PORT_BITS+1)'(NUM_OUT_PORTS));
    anyOverflow = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      updHit[i]    = bus.credit_upd_vld && (bus.credit_upd_port == NUM_PORT_BITS'(i));
      creditSum[i] = {1'b0, credit_q[i]}
                   + (updHit[i] ? {1'b0, bus.credit_upd_amount} : '0)
                   - {{CW{1'b0}}, grantOneHot[i]};
      if (creditSum[i] > {1'b0, CREDIT_MAX}) begin
        credit_d[i] = CREDIT_MAX;
        anyOverflow = 1'b1;
      end else begin
        credit_d[i] = creditSum[i][CW-1:0];
      end
      wptr_d[i] = grantOneHot[i] ? wptr_q[i] + NUM_ADDR_BITS'(1) : wptr_q[i];
    end
    creditErr_d = creditErr_q | anyOverflow | updBadPort;
    lastGrant_d = grantVld ? grantIdx : lastGrant_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= CREDIT_MAX;
        wptr_q[i]   <= '0;
      end
      lastGrant_q <= GW'(NUM_OUT_PORTS - 1);
      dout_q      <= '0;
      creditErr_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        wptr_q[i]   <= wptr_d[i];
      end
      lastGrant_q <= lastGrant_d;
      dout_q      <= dout_d;
      creditErr_q <= creditErr_d;
    end
  end

  assign bus.ack_interface2user      = grantOneHot;
  assign bus.dout_leaf_interface2bft = dout_q;
  assign bus.credit_err              = creditErr_q;

endmodule
